// File: rtl/polar_encoder.sv
// polar_encoder: serial-load polar encoder, one butterfly stage per cycle, registered codeword.
// Optional macro POLAR_ENC_BIT_REVERSE_EN emits the codeword in bit-reversed index order.
module polar_encoder #(
  parameter int unsigned              N_LOG2    = 3,
  parameter logic [(1<<N_LOG2)-1:0]   INFO_MASK = 8'hE8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_bit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [(1<<N_LOG2)-1:0]   codeword
);
  localparam int unsigned N  = 1 << N_LOG2;
  localparam int unsigned K  = $countones(INFO_MASK);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = $clog2(N_LOG2 + 1);

  typedef enum logic [1:0] {ST_LOAD, ST_ENCODE, ST_OUTPUT} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      u_q, u_d;
  logic [CW-1:0]     info_cnt_q, info_cnt_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [N-1:0]      cw_q, cw_d;
  logic [N-1:0]      u_load;
  logic [N-1:0]      u_stage;

  function automatic logic [N-1:0] out_map(input logic [N-1:0] x);
`ifdef POLAR_ENC_BIT_REVERSE_EN
    logic [N_LOG2-1:0] idx;
    logic [N_LOG2-1:0] rev;
    out_map = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx          = i[N_LOG2-1:0];
      rev          = {<<{idx}};
      out_map[idx] = x[rev];
    end
`else
    out_map = x;
`endif
  endfunction

  // The rank of each information position is fixed by INFO_MASK, so this reduces to compares.
  always_comb begin
    int unsigned rank;
    u_load = u_q;
    rank   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (INFO_MASK[i[N_LOG2-1:0]]) begin
        if (32'(info_cnt_q) == rank) u_load[i[N_LOG2-1:0]] = in_bit;
        rank++;
      end
    end
  end

  always_comb begin
    logic [N_LOG2-1:0] idx;
    logic [N_LOG2-1:0] bit_s;
    u_stage = u_q;
    idx     = '0;
    bit_s   = N_LOG2'(1) << stage_q;
    for (int unsigned i = 0; i < N; i++) begin
      idx = i[N_LOG2-1:0];
      if ((idx & bit_s) == '0) u_stage[idx] = u_q[idx] ^ u_q[idx | bit_s];
    end
  end

  always_comb begin
    state_d    = state_q;
    u_d        = u_q;
    info_cnt_d = info_cnt_q;
    stage_d    = stage_q;
    cw_d       = cw_q;
    unique case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          u_d        = u_load;
          info_cnt_d = info_cnt_q + CW'(1);
          if (info_cnt_q == CW'(K - 1)) begin
            state_d = ST_ENCODE;
            stage_d = '0;
          end
        end
      end
      ST_ENCODE: begin
        u_d = u_stage;
        if (stage_q == SW'(N_LOG2 - 1)) begin
          state_d = ST_OUTPUT;
          cw_d    = out_map(u_stage);
        end else begin
          stage_d = stage_q + SW'(1);
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_d    = ST_LOAD;
          u_d        = '0;
          info_cnt_d = '0;
          stage_d    = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      u_q        <= '0;
      info_cnt_q <= '0;
      stage_q    <= '0;
      cw_q       <= '0;
    end else begin
      state_q    <= state_d;
      u_q        <= u_d;
      info_cnt_q <= info_cnt_d;
      stage_q    <= stage_d;
      cw_q       <= cw_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD) && !rst;
  assign out_valid = (state_q == ST_OUTPUT);
  assign codeword  = cw_q;

endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder: two instances (default mask and all-information mask)
// checked against a superset-XOR reference model.
module tb_polar_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sel, in_valid, in_bit, out_ready;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] a_cw, b_cw;
  logic       s_in_ready, s_out_valid;
  logic [7:0] s_cw;

  assign a_in_valid  = in_valid  & ~sel;
  assign b_in_valid  = in_valid  &  sel;
  assign a_out_ready = out_ready & ~sel;
  assign b_out_ready = out_ready &  sel;
  assign s_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign s_out_valid = sel ? b_out_valid : a_out_valid;
  assign s_cw        = sel ? b_cw        : a_cw;

  polar_encoder #(.N_LOG2(3), .INFO_MASK(8'hE8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bit(in_bit),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .codeword(a_cw)
  );

  polar_encoder #(.N_LOG2(3), .INFO_MASK(8'hFF)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bit(in_bit),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .codeword(b_cw)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] enc_model(input logic [7:0] mask, input logic [7:0] bits);
    logic [7:0] u, x, r;
    int k;
    u = '0;
    k = 0;
    for (int i = 0; i < 8; i++)
      if (mask[i]) begin
        u[i] = bits[k];
        k++;
      end
    x = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if ((j & i) == i) x[i] = x[i] ^ u[j];
`ifdef POLAR_ENC_BIT_REVERSE_EN
    for (int i = 0; i < 8; i++) r[i] = x[((i & 1) << 2) | (i & 2) | ((i >> 2) & 1)];
`else
    r = x;
`endif
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [7:0] mask, input logic [7:0] bits, input string tag);
    int k;
    int lat;
    logic [7:0] exp;
    k   = $countones(mask);
    exp = enc_model(mask, bits);
    for (int i = 0; i < k; i++) begin
      check({tag, "/in_ready"}, 32'(s_in_ready), 32'd1);
      in_valid = 1'b1;
      in_bit   = bits[i];
      step();
    end
    in_valid = 1'b0;
    lat = 0;
    while (s_out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'd3);
    check({tag, "/codeword"}, 32'(s_cw), 32'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "/out_valid_drop"}, 32'(s_out_valid), 32'd0);
    check({tag, "/ready_back"}, 32'(s_in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bits, hold, acc;
    logic [7:0] exp_q[$];
    int lat, cnt, last_out, nout;

    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("reset/a_in_ready", 32'(a_in_ready), 32'd0);
    check("reset/b_in_ready", 32'(b_in_ready), 32'd0);
    check("reset/out_valid", 32'(a_out_valid | b_out_valid), 32'd0);
    check("reset/a_codeword", 32'(a_cw), 32'd0);
    check("reset/b_codeword", 32'(b_cw), 32'd0);
    rst = 1'b0;
    step();
    check("release/a_in_ready", 32'(a_in_ready), 32'd1);
    check("release/b_in_ready", 32'(b_in_ready), 32'd1);

    // Abort a block after two bits, then encode 1,0,0,0.
    in_valid = 1'b1; in_bit = 1'b1; step();
    in_bit = 1'b0; step();
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("midrst/in_ready", 32'(a_in_ready), 32'd0);
    step();
    check("midrst/out_valid", 32'(a_out_valid), 32'd0);
    check("midrst/codeword", 32'(a_cw), 32'd0);
    rst = 1'b0;
    step();
    run_block(8'hE8, 8'h01, "rst_recover");

    run_block(8'hE8, 8'h08, "dflt_0001");
    run_block(8'hE8, 8'h0F, "dflt_1111");
    run_block(8'hE8, 8'h00, "dflt_0000");

    sel = 1'b1;
    run_block(8'hFF, 8'h80, "full_u80");
    run_block(8'hFF, 8'h01, "full_u01");
    run_block(8'hFF, 8'h03, "full_u03");
    for (int r = 0; r < 4; r++) run_block(8'hFF, 8'($urandom), "full_rand");

    sel = 1'b0;
    for (int r = 0; r < 6; r++) run_block(8'hE8, 8'($urandom), "dflt_rand");

    // Backpressure: hold the codeword for 10 cycles while in_valid toggles.
    bits = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_bit = bits[i]; step();
    end
    in_valid = 1'b0;
    lat = 0;
    while (a_out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check("bp/latency", 32'(lat), 32'd3);
    hold = a_cw;
    check("bp/codeword", 32'(hold), 32'(enc_model(8'hE8, bits)));
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_bit   = 1'($urandom_range(0, 1));
      step();
      check("bp/stable", 32'(a_cw), 32'(hold));
      check("bp/in_ready_low", 32'(a_in_ready), 32'd0);
      check("bp/out_valid_held", 32'(a_out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    run_block(8'hE8, 8'($urandom), "bp_next");

    // Back-to-back with in_valid and out_ready tied high.
    in_valid = 1'b1; out_ready = 1'b1;
    acc = '0; cnt = 0; last_out = -1; nout = 0;
    for (int c = 0; c < 40; c++) begin
      in_bit = 1'($urandom_range(0, 1));
      if (a_in_ready) begin
        acc[cnt] = in_bit;
        cnt++;
        if (cnt == 4) begin
          exp_q.push_back(enc_model(8'hE8, acc));
          cnt = 0;
        end
      end
      if (a_out_valid) begin
        check("b2b/pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("b2b/codeword", 32'(a_cw), 32'(exp_q.pop_front()));
        if (last_out >= 0) check("b2b/period", 32'(c - last_out), 32'd8);
        last_out = c;
        nout++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b/count", 32'(nout), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
